// File: rtl/dsp_result_collector.sv
// dsp_result_collector
//   Tracks operations issued into a DSP48A1-style slice through a LATENCY-deep
//   tag pipeline, captures P/CARRYOUT on the cycle each result emerges, buffers
//   the results in a first-word-fall-through FIFO and hands them downstream on
//   a valid/ready handshake. Upstream is throttled by credits so that every
//   in-flight operation is guaranteed a FIFO slot.
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous active-low reset
//   pipe_ce      slice advance enable; 0 freezes the tag pipeline
//   issue_valid  upstream offers an operation this cycle
//   issue_ready  a credit is available (registered occupancy only)
//   P, CARRYOUT  slice outputs, sampled when a tag reaches the last stage
//   m_valid      FIFO head valid
//   m_ready      downstream accepts the head
//   m_data       captured P at the head (holds the last popped value when empty)
//   m_carry      captured CARRYOUT at the head
//   occupancy    in-flight tags plus buffered entries
module dsp_result_collector #(
  parameter int WIDTH   = 48,
  parameter int LATENCY = 4,
  parameter int DEPTH   = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     pipe_ce,
  input  logic                     issue_valid,
  output logic                     issue_ready,
  input  logic [WIDTH-1:0]         P,
  input  logic                     CARRYOUT,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [WIDTH-1:0]         m_data,
  output logic                     m_carry,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int AW = $clog2(DEPTH);
  localparam int OW = AW + 1;

  logic [LATENCY-1:0] tag_q, tag_d;
  logic [WIDTH-1:0]   mem_data_q [DEPTH];
  logic [DEPTH-1:0]   mem_carry_q;
  logic [AW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [OW-1:0]      cnt_q, cnt_d;
  logic [OW-1:0]      occ_q, occ_d;
  logic [WIDTH-1:0]   last_data_q;
  logic               last_carry_q;

  logic accept, push, pop;

  // Credit check uses only registered occupancy, so there is no combinational
  // path from m_ready or issue_valid to issue_ready.
  assign issue_ready = rst & (occ_q < OW'(DEPTH));
  assign accept      = issue_valid & issue_ready & pipe_ce;
  assign push        = pipe_ce & tag_q[LATENCY-1];
  assign m_valid     = (cnt_q != '0);
  assign pop         = m_valid & m_ready;
  assign occupancy   = occ_q;

  // Head is read straight from storage; when empty the last popped value is
  // shown instead so the outputs do not wander onto stale slots.
  assign m_data  = m_valid ? mem_data_q[rd_ptr_q]  : last_data_q;
  assign m_carry = m_valid ? mem_carry_q[rd_ptr_q] : last_carry_q;

  always_comb begin
    tag_d    = tag_q;
    tag_d[0] = accept;
    for (int i = 1; i < LATENCY; i++) tag_d[i] = tag_q[i-1];
  end

  // A tag moving into the FIFO is occupancy-neutral; only accept and pop move it.
  always_comb begin
    cnt_d = cnt_q + OW'(push) - OW'(pop);
    occ_d = occ_q + OW'(accept) - OW'(pop);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      tag_q        <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      cnt_q        <= '0;
      occ_q        <= '0;
      last_data_q  <= '0;
      last_carry_q <= 1'b0;
    end else begin
      if (pipe_ce) tag_q <= tag_d;
      if (push) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_q     <= rd_ptr_q + AW'(1);
        last_data_q  <= mem_data_q[rd_ptr_q];
        last_carry_q <= mem_carry_q[rd_ptr_q];
      end
      cnt_q <= cnt_d;
      occ_q <= occ_d;
    end
  end

  // Storage needs no reset: entries are only visible while counted valid.
  always_ff @(posedge clk) begin
    if (rst && push) begin
      mem_data_q[wr_ptr_q]  <= P;
      mem_carry_q[wr_ptr_q] <= CARRYOUT;
    end
  end

endmodule

// File: tb/tb_dsp_result_collector.sv
module tb_dsp_result_collector;
  localparam int W = 48;
  localparam int L = 4;
  localparam int D = 4;

  logic clk = 1'b0;
  logic rst, pipe_ce, issue_valid, issue_ready, CARRYOUT, m_valid, m_ready, m_carry;
  logic [W-1:0] P, m_data;
  logic [$clog2(D):0] occupancy;

  always #5 clk = ~clk;

  dsp_result_collector #(.WIDTH(W), .LATENCY(L), .DEPTH(D)) dut (
    .clk(clk), .rst(rst), .pipe_ce(pipe_ce), .issue_valid(issue_valid),
    .issue_ready(issue_ready), .P(P), .CARRYOUT(CARRYOUT), .m_valid(m_valid),
    .m_ready(m_ready), .m_data(m_data), .m_carry(m_carry), .occupancy(occupancy)
  );

  typedef struct { logic [W-1:0] d; logic c; } res_t;

  int tests = 0;
  int fails = 0;
  res_t exp_q[$];   // scoreboard: expected results in delivery order
  res_t mq[$];      // model of buffered results
  int   inflight[$]; // remaining pipe_ce edges until capture, per op in issue order
  logic [W-1:0] last_d = '0;
  logic         last_c = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: results are sampled on the L-th enabled edge after issue,
  // credits are simply (ops in flight + results held) < D.
  always @(negedge clk) begin
    automatic int  occ = inflight.size() + mq.size();
    automatic bit  exp_rdy = (rst === 1'b1) && (occ < D);
    chk("issue_ready", 64'(issue_ready), 64'(exp_rdy));
    chk("occupancy", 64'(occupancy), 64'(occ));
    chk("m_valid", 64'(m_valid), 64'(mq.size() != 0));
    if (mq.size() == 0) begin
      chk("m_data_hold", 64'(m_data), 64'(last_d));
      chk("m_carry_hold", 64'(m_carry), 64'(last_c));
    end
    if (rst !== 1'b1) begin
      inflight.delete(); mq.delete(); exp_q.delete();
      last_d = '0; last_c = 1'b0;
    end else begin
      if (mq.size() != 0 && m_ready) begin
        last_d = mq[0].d; last_c = mq[0].c;
        void'(mq.pop_front());
      end
      if (pipe_ce) begin
        foreach (inflight[i]) inflight[i]--;
        if (inflight.size() != 0 && inflight[0] == 0) begin
          automatic res_t r;
          r.d = P; r.c = CARRYOUT;
          mq.push_back(r); exp_q.push_back(r);
          void'(inflight.pop_front());
        end
        if (issue_valid && exp_rdy) inflight.push_back(L);
      end
    end
  end

  // Monitor: every handshake must match the next expected result.
  always @(negedge clk) begin
    if (rst === 1'b1 && m_valid === 1'b1 && m_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("stale_result", 64'(m_valid), 64'(0));
      end else begin
        automatic res_t e = exp_q.pop_front();
        chk("m_data", 64'(m_data), 64'(e.d));
        chk("m_carry", 64'(m_carry), 64'(e.c));
      end
    end
  end

  task automatic cyc(input bit rv, input bit iv, input bit ce, input bit rdy);
    @(posedge clk); #1;
    rst = rv; issue_valid = iv; pipe_ce = ce; m_ready = rdy;
    P = {$urandom, $urandom}; CARRYOUT = 1'($urandom);
  endtask

  task automatic rnd(input int n, input int piv, input int pce, input int prdy);
    for (int i = 0; i < n; i++)
      cyc(1'b1, $urandom_range(99) < piv, $urandom_range(99) < pce, $urandom_range(99) < prdy);
  endtask

  initial begin
    rst = 1'b0; issue_valid = 1'b0; pipe_ce = 1'b1; m_ready = 1'b0;
    P = '0; CARRYOUT = 1'b0;
    repeat (3) cyc(1'b0, 1'b1, 1'b1, 1'b1);
    // single op through an idle pipe
    cyc(1'b1, 1'b1, 1'b1, 1'b1);
    repeat (10) cyc(1'b1, 1'b0, 1'b1, 1'b1);
    // credit exhaustion, one pop, then drain
    repeat (10) cyc(1'b1, 1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b1, 1'b1);
    repeat (3) cyc(1'b1, 1'b0, 1'b1, 1'b0);
    repeat (12) cyc(1'b1, 1'b0, 1'b1, 1'b1);
    // freeze right after issue; issue attempts during freeze are ignored
    cyc(1'b1, 1'b1, 1'b1, 1'b1);
    repeat (3) cyc(1'b1, 1'b1, 1'b0, 1'b1);
    repeat (10) cyc(1'b1, 1'b0, 1'b1, 1'b1);
    // streaming
    repeat (30) cyc(1'b1, 1'b1, 1'b1, 1'b1);
    // mixed random traffic
    rnd(300, 60, 80, 60);
    rnd(200, 90, 95, 30);
    rnd(200, 40, 50, 90);
    // reset with ops both in flight and buffered
    repeat (6) cyc(1'b1, 1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 1'b1);
    repeat (10) cyc(1'b1, 1'b0, 1'b1, 1'b1);
    rnd(300, 70, 85, 70);
    // drain
    repeat (20) cyc(1'b1, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    chk("drained", 64'(exp_q.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
